// File: rtl/upsample_pkg.sv
// Shared audio constants, the reciprocal table for the 1/N interpolation slope and output saturation.
// Both the decimator and the interpolator use SAMPLE_W and NFREQ_W.
package upsample_pkg;

    localparam int SAMPLE_W = 18;
    localparam int NFREQ_W  = 4;

    // RECIP[n] = round(65536/n); entry 0 mirrors N=1 because a zero rate factor runs as N=1
    localparam logic [16:0] RECIP [0:15] = '{
        17'd65536, 17'd65536, 17'd32768, 17'd21845,
        17'd16384, 17'd13107, 17'd10923, 17'd9362,
        17'd8192,  17'd7282,  17'd6554,  17'd5958,
        17'd5461,  17'd5041,  17'd4681,  17'd4369
    };

    function automatic logic signed [SAMPLE_W-1:0] sat18(input logic signed [19:0] x);
        logic signed [SAMPLE_W-1:0] r;
        if (x > 20'sd131071)
            r = 18'sd131071;
        else if (x < -20'sd131072)
            r = -18'sd131072;
        else
            r = x[SAMPLE_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/upsample_interp.sv
// Linear-interpolation datapath: holds the per-tick slope and the running accumulator, and saturates the output.
// Combinational output from registered acc; no backpressure. Exists only when UPSAMPLE_LININTERP_EN is defined.
`ifdef UPSAMPLE_LININTERP_EN
module upsample_interp
    import upsample_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       tick,
    input  logic                       advance,
    input  logic signed [SAMPLE_W-1:0] cur,
    input  logic signed [SAMPLE_W-1:0] datain,
    input  logic [NFREQ_W-1:0]         n,
    output logic signed [SAMPLE_W-1:0] lin_out
);

    logic signed [19:0] acc;
    logic signed [19:0] step;
    logic signed [18:0] diff;
    logic signed [35:0] prod;
    logic signed [19:0] step_new;

    assign diff     = 19'(datain) - 19'(cur);
    assign prod     = 36'(diff) * 36'($signed({1'b0, RECIP[n]}));
    assign step_new = 20'(prod >>> 16);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            step <= '0;
        end else if (start) begin
            step <= step_new;
            // a coincident tick consumes the first point of the new segment immediately
            acc  <= tick ? 20'(cur) + step_new : 20'(cur);
        end else if (tick && advance) begin
            acc <= acc + step;
        end
    end

    // on a capture cycle acc still holds the previous segment, but the segment's first point is the old cur
    assign lin_out = (start || !advance) ? cur : sat18(acc);

endmodule
`endif

// File: rtl/upsample.sv
// Interpolator Fs/N -> 48 kHz: zero-order hold, or linear interpolation when UPSAMPLE_LININTERP_EN is defined.
// Output registered one clock after en48; no backpressure, one output per tick, underrun flags starved segments.
module upsample
    import upsample_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NFREQ_W-1:0]         Nfreq,
    input  logic signed [SAMPLE_W-1:0] datain,
    input  logic                       endatain,
    input  logic                       en48,
    output logic signed [SAMPLE_W-1:0] dataout,
    output logic                       endataout,
    output logic                       underrun
);

    logic signed [SAMPLE_W-1:0] cur;
    logic [NFREQ_W-1:0]         phase;
    logic [NFREQ_W-1:0]         nreg;
    logic [NFREQ_W-1:0]         ucnt;
    logic [NFREQ_W-1:0]         n_new;
    logic signed [SAMPLE_W-1:0] out_nxt;

    assign n_new = (Nfreq == '0) ? 4'd1 : Nfreq;

`ifdef UPSAMPLE_LININTERP_EN
    upsample_interp u_interp (
        .clock   (clock),
        .reset   (reset),
        .start   (endatain),
        .tick    (en48),
        .advance (phase != nreg),
        .cur     (cur),
        .datain  (datain),
        .n       (n_new),
        .lin_out (out_nxt)
    );
`else
    assign out_nxt = endatain ? datain : cur;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur       <= '0;
            phase     <= '0;
            nreg      <= 4'd1;
            ucnt      <= '0;
            dataout   <= '0;
            endataout <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            endataout <= en48;
            underrun  <= 1'b0;
            if (en48)
                dataout <= out_nxt;
            if (endatain) begin
                cur   <= datain;
                nreg  <= n_new;
                ucnt  <= '0;
                phase <= en48 ? 4'd1 : 4'd0;
            end else if (en48) begin
                if (phase != nreg) begin
                    phase <= phase + 4'd1;
                end else begin
                    // starved: flag on the first idle tick, then once per further N ticks
                    underrun <= (ucnt == '0);
                    ucnt     <= (ucnt == nreg - 4'd1) ? 4'd0 : ucnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/upsample.md
# upsample

Sample-rate interpolator: accepts 18-bit signed audio words at Fs/Nfreq and regenerates a 48 kHz stream, using zero-order hold or, when compiled in, linear interpolation. It sits on the output side of the decimated processing path, ahead of the 48 kHz DAC interface, and is the counterpart of the decimator (`downsample`) at the head of that path. One output word and one `endataout` pulse are produced per 48 kHz tick, regardless of input arrival.

## Interface
- No parameters; widths fixed at 18-bit data, 4-bit rate factor.
- clock  input  1  master clock
- reset  input  1  asynchronous, active-low reset
- Nfreq  input  4  interpolation factor N; 0 treated as 1
- datain  input  18  input sample, signed two's complement
- endatain  input  1  one-clock strobe, input sample valid (nominal rate 48 kHz/N)
- en48  input  1  one-clock 48 kHz tick; ticks at least 4 clocks apart
- dataout  output  18  output sample, signed
- endataout  output  1  one-clock strobe, output valid, Fs = 48 kHz
- underrun  output  1  one-clock pulse, N ticks elapsed with no new input

## Operation
- State: `cur` (latest input), `base` (previous input), `phase` counter 0..N, `acc` (20-bit signed), `step` (20-bit signed).
- N is sampled into `nreg` on each `endatain`; mid-segment Nfreq changes take effect at the next input.
- On `endatain`: `base<=cur`, `cur<=datain`, `phase<=0`, `acc<=cur` (old value).
- On `en48`: output per mode, `endataout<=1`, `phase<=phase+1` saturating at `nreg`.
- Zero-order hold: `dataout<=cur`; if `endatain` and `en48` coincide, the new `datain` is output (bypass).
- When `phase` reaches `nreg` on a tick with no `endatain` in the same cycle: `underrun` pulses once; output keeps holding `cur`. It pulses again only after a further full N ticks without input.
- `endatain` with no `en48`: state updates only; no output.

## Timing
- Reset (asserted): `dataout=0`, `endataout=0`, `underrun=0`, `cur=base=acc=step=0`, `phase=0`, `nreg=1`. Reset mid-segment discards all state immediately.
- `dataout`/`endataout` are registered and valid the clock after `en48`.
- ZOH latency: input to output = next tick (0 input periods).
- Linear mode latency: one input period (interpolates between `base` and `cur`).
- `endataout` is high for exactly one clock per `en48`. It is never asserted without `en48`.

## Configuration
- `UPSAMPLE_LININTERP_EN` defined → linear interpolation:
  - On `endatain`: `diff = datain - cur` (19-bit signed). `step <= (diff * RECIP[N]) >>> 16`, a 36-bit signed product with arithmetic shift, computed combinationally in that cycle.
  - On a tick with `phase < nreg`: `dataout <= sat18(acc)`, `acc <= acc + step`.
  - On a tick with `phase == nreg`: `dataout <= cur` exactly; `acc` is frozen.
  - When `endatain` and `en48` coincide: capture first, then `dataout <= old cur` and `acc <= old cur + new step`.
  - `sat18` clamps to −131072..131071.
- Not defined → zero-order hold only. `step`, `acc`, the multiplier and the reciprocal table are not synthesized; the ports are identical.

## Structure
- Shared audio package holds:
  - `SAMPLE_W = 18`
  - `NFREQ_W = 4`
  - `RECIP[1..15] = round(65536/N)`, 17-bit unsigned; `RECIP[1] = 65536`
  - the `sat18` function
- The decimator (`downsample`) also uses `SAMPLE_W` and `NFREQ_W`.
- One sub-module: `upsample_interp`, holding `step`/`acc` and the saturation. It is instantiated only under `UPSAMPLE_LININTERP_EN`.

## Test plan
- **Reset:** assert reset mid-segment → all outputs 0 asynchronously. After release, the first `en48` gives `dataout=0`, `endataout=1`.
- **ZOH, Nfreq=4:** inputs 1000, then −2000 every 4 ticks → output 1000×4 then −2000×4. Exactly one `endataout` per tick; `underrun` never asserted.
- **Linear, Nfreq=4:** inputs 0 then 4000 → over the next segment, outputs 0, 1000, 2000, 3000, followed by 4000 at the next segment start.
- **Linear saturation, Nfreq=2:** inputs 131071 then −131072 → outputs stay within range, with a midpoint of about 0 or −1.
- **Underrun, Nfreq=3:** stop inputs after 500 → `underrun` pulses once after the 3rd tick. Output holds 500 on every subsequent tick, and `underrun` pulses again every 3 further ticks.
- **Nfreq=0 and coincident events:** Nfreq=0 behaves as N=1. `endatain` and `en48` in the same cycle give ZOH bypass of the new sample, or linear output of the old `cur`.
